// File: rtl/piso_stuff_serializer_if.sv
// Transmit bit-path bus between the packet framer / bit-rate strobe source
// (master) and the stuffing serializer (slave).
interface piso_stuff_serializer_if #(
  parameter int WIDTH = 8
);
  // framer -> serializer
  logic             shift_enable;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             run_clr;
  // serializer -> framer / NRZI encoder
  logic             ready;
  logic             serial_out;
  logic             stuff_bit;
  logic             busy;
  logic             done;

  modport master (
    output shift_enable, load, data_in, run_clr,
    input  ready, serial_out, stuff_bit, busy, done
  );

  modport slave (
    input  shift_enable, load, data_in, run_clr,
    output ready, serial_out, stuff_bit, busy, done
  );
endinterface

// File: rtl/piso_stuff_serializer.sv
// Parallel-in/serial-out USB transmit serializer with bit stuffing.
// A word is latched on load && ready and sent one bit per shift_enable
// strobe, LSB- or MSB-first. With stuffing enabled, a zero is inserted after
// STUFF_RUN consecutive data ones; the run count survives word boundaries
// and idle gaps so stuffing stays correct across a multi-word packet.
// WIDTH must be >= 2, STUFF_RUN must be >= 1.
module piso_stuff_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   LSB_FIRST  = 1,
  parameter int   STUFF_EN   = 1,
  parameter int   STUFF_RUN  = 6,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic                      clk,
  input logic                      nRST,
  piso_stuff_serializer_if.slave   bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int OW = $clog2(STUFF_RUN + 1);

  // IDLE: busy=0; DATA: busy, no stuff pending; STUFF: busy, stuff pending
  typedef enum logic [1:0] {IDLE, DATA, STUFF} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt, sreg_shift;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [OW-1:0]    ones_cnt, ones_nxt, ones_sat, ones_upd;
  logic             done_r, done_nxt;

  logic cur_bit;    // data bit currently at the output end of sreg
  logic last_bit;   // cur_bit is the final data bit of the word
  logic tail;       // in STUFF: every data bit already consumed
  logic stuff_hit;  // this data shift completes a run of STUFF_RUN ones

  assign cur_bit    = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];
  assign sreg_shift = (LSB_FIRST != 0) ? {1'b0, sreg[WIDTH-1:1]}
                                       : {sreg[WIDTH-2:0], 1'b0};
  assign last_bit   = (bit_cnt == BW'(WIDTH - 1));
  // bit_cnt is zeroed when the last data bit goes out, and a mid-word stuff
  // always follows at least one data bit, so zero in STUFF marks the tail.
  assign tail       = (bit_cnt == '0);

  // Saturate so a long run with stuffing disabled cannot wrap the counter.
  assign ones_sat  = (ones_cnt == OW'(STUFF_RUN)) ? ones_cnt : ones_cnt + 1'b1;
  assign ones_upd  = cur_bit ? ones_sat : '0;
  assign stuff_hit = (STUFF_EN != 0) && !bus.run_clr &&
                     (ones_upd == OW'(STUFF_RUN));

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= done_nxt;
    end
  end

  // Next-state decode; done fires on every busy -> IDLE transition
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load) state_nxt = DATA;
      end
      DATA: begin
        if (bus.shift_enable) begin
          if (stuff_hit) begin
            state_nxt = STUFF;
          end else if (last_bit) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      STUFF: begin
        // run_clr drops the pending stuff bit just as consuming it would
        if (bus.shift_enable || bus.run_clr) begin
          if (tail) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.ready     = (state == IDLE);
    bus.stuff_bit = (state == STUFF);
    bus.done      = done_r;
    unique case (state)
      DATA:    bus.serial_out = cur_bit;
      STUFF:   bus.serial_out = 1'b0;
      default: bus.serial_out = IDLE_LEVEL;
    endcase
  end

  // Datapath next values: word load, shifting, bit and ones-run counting
  always_comb begin
    sreg_nxt    = sreg;
    bit_cnt_nxt = bit_cnt;
    ones_nxt    = ones_cnt;
    unique case (state)
      IDLE: begin
        if (bus.load) begin
          sreg_nxt    = bus.data_in;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (bus.shift_enable) begin
          sreg_nxt    = sreg_shift;
          bit_cnt_nxt = last_bit ? '0 : bit_cnt + 1'b1;
          ones_nxt    = ones_upd;
        end
      end
      STUFF: begin
        if (bus.shift_enable) ones_nxt = '0;
      end
      default: ;
    endcase
    // run_clr wins over any run update in the same cycle
    if (bus.run_clr) ones_nxt = '0;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else begin
      sreg     <= sreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      ones_cnt <= ones_nxt;
    end
  end

endmodule

// File: tb/tb_piso_stuff_serializer.sv
// Directed bench: three serializer instances (LSB-first stuffing, MSB-first
// stuffing, stuffing disabled) driven one at a time from a single sequence.
module tb_piso_stuff_serializer;

  logic       clk;
  logic       nrst;
  logic [2:0] ld, se, rc;
  logic [7:0] din;
  logic [2:0] so, sb, rdy, bsy, dn;

  int checks   = 0;
  int failures = 0;

  piso_stuff_serializer_if #(.WIDTH(8)) bus_a ();
  piso_stuff_serializer_if #(.WIDTH(8)) bus_b ();
  piso_stuff_serializer_if #(.WIDTH(8)) bus_c ();

  piso_stuff_serializer #(.WIDTH(8), .LSB_FIRST(1), .STUFF_EN(1), .STUFF_RUN(6), .IDLE_LEVEL(1'b1))
    u_a (.clk(clk), .nRST(nrst), .bus(bus_a));
  piso_stuff_serializer #(.WIDTH(8), .LSB_FIRST(0), .STUFF_EN(1), .STUFF_RUN(6), .IDLE_LEVEL(1'b1))
    u_b (.clk(clk), .nRST(nrst), .bus(bus_b));
  piso_stuff_serializer #(.WIDTH(8), .LSB_FIRST(1), .STUFF_EN(0), .STUFF_RUN(6), .IDLE_LEVEL(1'b1))
    u_c (.clk(clk), .nRST(nrst), .bus(bus_c));

  assign bus_a.load = ld[0]; assign bus_a.shift_enable = se[0];
  assign bus_a.run_clr = rc[0]; assign bus_a.data_in = din;
  assign bus_b.load = ld[1]; assign bus_b.shift_enable = se[1];
  assign bus_b.run_clr = rc[1]; assign bus_b.data_in = din;
  assign bus_c.load = ld[2]; assign bus_c.shift_enable = se[2];
  assign bus_c.run_clr = rc[2]; assign bus_c.data_in = din;

  assign so  = {bus_c.serial_out, bus_b.serial_out, bus_a.serial_out};
  assign sb  = {bus_c.stuff_bit,  bus_b.stuff_bit,  bus_a.stuff_bit};
  assign rdy = {bus_c.ready,      bus_b.ready,      bus_a.ready};
  assign bsy = {bus_c.busy,       bus_b.busy,       bus_a.busy};
  assign dn  = {bus_c.done,       bus_b.done,       bus_a.done};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load d into instance s at the current negedge, then strobe n times.
  // Bit i on the line (before strobe i) lands in so_seq[i]/sb_seq[i].
  // held stays 1 only if busy=1 and done=0 at every strobe point.
  // At strobe index poke a second load with 0xFF is attempted (must be ignored).
  task automatic send(input int s, input logic [7:0] d, input int n, input int poke,
                      output logic [15:0] so_seq, output logic [15:0] sb_seq,
                      output logic held);
    so_seq = '0; sb_seq = '0; held = 1'b1;
    ld[s] = 1'b1; din = d;
    @(negedge clk);
    ld[s] = 1'b0; din = 8'h00;
    for (int i = 0; i < n; i++) begin
      so_seq[i] = so[s];
      sb_seq[i] = sb[s];
      if (!bsy[s] || dn[s]) held = 1'b0;
      se[s] = 1'b1;
      if (i == poke) begin ld[s] = 1'b1; din = 8'hFF; end
      else ld[s] = 1'b0;
      @(negedge clk);
    end
    se[s] = 1'b0; ld[s] = 1'b0; din = 8'h00;
  endtask

  // Word-complete cycle: done pulse, busy low, ready back high
  task automatic end_chk(input int s, input string tag);
    chk({tag, "_done"},  32'(dn[s]),  32'd1);
    chk({tag, "_busy"},  32'(bsy[s]), 32'd0);
    chk({tag, "_ready"}, 32'(rdy[s]), 32'd1);
  endtask

  logic [15:0] sq, sbq;
  logic        hd;

  initial begin
    nrst = 1'b0; ld = '0; se = '0; rc = '0; din = '0;
    repeat (2) @(negedge clk);
    chk("rst_serial_out", 32'(so[0]),  32'd1);
    chk("rst_stuff_bit",  32'(sb[0]),  32'd0);
    chk("rst_ready",      32'(rdy[0]), 32'd1);
    chk("rst_busy",       32'(bsy[0]), 32'd0);
    chk("rst_done",       32'(dn[0]),  32'd0);
    chk("rst_ones",       32'(u_a.ones_cnt), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // LSB-first 0xA5: 1,0,1,0,0,1,0,1
    send(0, 8'hA5, 8, -1, sq, sbq, hd);
    chk("a5_seq",   32'(sq),  32'h00A5);
    chk("a5_stuff", 32'(sbq), 32'h0000);
    chk("a5_held",  32'(hd),  32'd1);
    end_chk(0, "a5");
    chk("a5_ones",  32'(u_a.ones_cnt), 32'd1);

    // MSB-first 0xB4: 1,0,1,1,0,1,0,0
    send(1, 8'hB4, 8, -1, sq, sbq, hd);
    chk("b4_seq",   32'(sq),  32'h002D);
    chk("b4_stuff", 32'(sbq), 32'h0000);
    chk("b4_held",  32'(hd),  32'd1);
    end_chk(1, "b4");

    // MSB-first 0x0F with a load attempt mid-word: 0,0,0,0,1,1,1,1
    send(1, 8'h0F, 8, 3, sq, sbq, hd);
    chk("busyload_seq", 32'(sq), 32'h00F0);
    end_chk(1, "busyload");

    // run_clr then 0xFF: 1x6, stuff, 1,1
    rc[0] = 1'b1;
    @(negedge clk);
    rc[0] = 1'b0;
    chk("runclr_ones", 32'(u_a.ones_cnt), 32'd0);
    send(0, 8'hFF, 9, -1, sq, sbq, hd);
    chk("ff1_seq",   32'(sq),  32'h01BF);
    chk("ff1_stuff", 32'(sbq), 32'h0040);
    chk("ff1_held",  32'(hd),  32'd1);
    end_chk(0, "ff1");
    chk("ff1_ones",  32'(u_a.ones_cnt), 32'd2);

    // second 0xFF with run=2 carried: 1x4, stuff, 1x4
    send(0, 8'hFF, 9, -1, sq, sbq, hd);
    chk("ff2_seq",   32'(sq),  32'h01EF);
    chk("ff2_stuff", 32'(sbq), 32'h0010);
    end_chk(0, "ff2");
    chk("ff2_ones",  32'(u_a.ones_cnt), 32'd4);

    // trailing stuff: 0xFC -> 0,0,1x6, stuff; busy held through the stuff bit
    send(0, 8'hFC, 9, -1, sq, sbq, hd);
    chk("fc_seq",   32'(sq),  32'h00FC);
    chk("fc_stuff", 32'(sbq), 32'h0100);
    chk("fc_held",  32'(hd),  32'd1);
    end_chk(0, "fc");
    chk("fc_ones",  32'(u_a.ones_cnt), 32'd0);

    // 0x3F: 1x6, stuff, 0,0 ; then 0xC0 ends with run=2, no stuff
    send(0, 8'h3F, 9, -1, sq, sbq, hd);
    chk("3f_seq",   32'(sq),  32'h003F);
    chk("3f_stuff", 32'(sbq), 32'h0040);
    end_chk(0, "3f");
    send(0, 8'hC0, 8, -1, sq, sbq, hd);
    chk("c0_seq",   32'(sq),  32'h00C0);
    chk("c0_stuff", 32'(sbq), 32'h0000);
    end_chk(0, "c0");
    chk("c0_ones",  32'(u_a.ones_cnt), 32'd2);

    // stuffing disabled: 0xFF twice, 16 ones, no stuff bits
    send(2, 8'hFF, 8, -1, sq, sbq, hd);
    chk("nostuff1_seq",   32'(sq),  32'h00FF);
    chk("nostuff1_stuff", 32'(sbq), 32'h0000);
    end_chk(2, "nostuff1");
    send(2, 8'hFF, 8, -1, sq, sbq, hd);
    chk("nostuff2_seq",   32'(sq),  32'h00FF);
    chk("nostuff2_stuff", 32'(sbq), 32'h0000);
    end_chk(2, "nostuff2");

    // reset mid-word after 3 strobes of 0xA5
    ld[0] = 1'b1; din = 8'hA5;
    @(negedge clk);
    ld[0] = 1'b0; se[0] = 1'b1;
    repeat (3) @(negedge clk);
    se[0] = 1'b0;
    nrst = 1'b0;
    #1;
    chk("abort_busy",       32'(bsy[0]), 32'd0);
    chk("abort_done",       32'(dn[0]),  32'd0);
    chk("abort_serial_out", 32'(so[0]),  32'd1);
    chk("abort_ready",      32'(rdy[0]), 32'd1);
    chk("abort_ones",       32'(u_a.ones_cnt), 32'd0);
    @(negedge clk);
    chk("abort_nodone", 32'(dn[0]), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    send(0, 8'h01, 8, -1, sq, sbq, hd);
    chk("post_seq",   32'(sq),  32'h0001);
    chk("post_stuff", 32'(sbq), 32'h0000);
    end_chk(0, "post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
